serial_subtractor: RTL and testbench



---
 rtl/serial_arith_pkg.sv | 19 +
 rtl/full_subtractor.sv | 19 +
 rtl/serial_subtractor.sv | 127 ++++++++++++
 tb/tb_serial_subtractor.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
//   state_t   : operation sequencer states (IDLE, RUN, DONE)
//   cnt_width : bit-counter width for a given operand width
package serial_arith_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must index bits 0..w-1; clamp so a 1-bit counter is never 0 wide.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow out.
//   a, b, bin : input bits
//   d, bout   : difference bit and borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign d     = w_axb ^ bin;
  // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
  assign bout  = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = (a - b - b_in) mod 2^WIDTH, LSB first,
// one bit per clock, with start/busy/done handshake.
//   clk, rst          : clock, synchronous active-high reset
//   start, a, b, b_in : request and operands, captured only in IDLE
//   busy              : high while bits are being processed
//   done              : one-cycle pulse when diff/borrow_out are fresh
//   diff, borrow_out  : result, held between operations
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_nxt;

  assign w_last = (r_cnt == LAST_BIT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output/control decode; busy/done are derived from the next state so the
  // registered flags line up with the state they describe.
  always_comb begin
    w_accept   = 1'b0;
    w_step     = 1'b0;
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    w_accept   = (r_state == IDLE) && start;
    w_step     = (r_state == RUN);
    w_busy_nxt = (w_state_nxt == RUN);
    w_done_nxt = (w_state_nxt == DONE);
  end

  full_subtractor u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bout)
  );

  // Result fills from the MSB side so bit 0 lands at the LSB after WIDTH steps.
  assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

  // Serial datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= b_in;
      r_cnt <= '0;
    end else if (w_step) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_res <= w_res_nxt;
      r_br  <= w_bout;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Registered outputs; result only updates on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      busy <= w_busy_nxt;
      done <= w_done_nxt;
      if (w_step && w_last) begin
        diff       <= w_res_nxt;
        borrow_out <= w_bout;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  int n_pass;
  int n_tot;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and sample 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Full operation from IDLE with exact cycle checks on busy/done.
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                    input logic [W-1:0] ed, input logic eb, input string tag);
    int busy_cnt;
    a = ta; b = tb; b_in = tbin; start = 1'b1;
    tick();                      // accepting edge N
    start = 1'b0;
    busy_cnt = 0;
    for (int k = 1; k < int'(W); k++) begin
      if (busy && !done) busy_cnt++;
      tick();
    end
    if (busy && !done) busy_cnt++;
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
    tick();                      // edge N+W
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_borrow"}, 32'(borrow_out), 32'(eb));
    tick();                      // back to IDLE
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int done_cnt;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic         ebin;
    logic [W:0]   model;

    n_pass = 0;
    n_tot  = 0;
    rst = 1'b1; start = 1'b1; a = 8'd1; b = 8'd0; b_in = 1'b0;

    // 1. Reset, with start asserted during reset
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    rst = 1'b0; start = 1'b0;
    tick();
    chk("rst_start_dropped", 32'(busy), 32'd0);

    // 2. Basic subtraction
    op(8'd200, 8'd55, 1'b0, 8'd145, 1'b0, "sub200_55");
    // 3. Borrow cases
    op(8'd5, 8'd9, 1'b0, 8'hFC, 1'b1, "sub5_9");
    op(8'd0, 8'd0, 1'b1, 8'hFF, 1'b1, "sub0_0_bin");
    op(8'h3C, 8'h3C, 1'b0, 8'h00, 1'b0, "sub_equal");
    op(8'd10, 8'd3, 1'b1, 8'd6, 1'b0, "sub10_3_bin");

    // 4. start during RUN is ignored
    a = 8'd100; b = 8'd1; b_in = 1'b0; start = 1'b1;
    tick();                      // edge N
    start = 1'b0;
    tick(); tick();              // N+1, N+2
    a = 8'd7; b = 8'd7; start = 1'b1;
    tick();                      // N+3
    start = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) done_cnt++;
      if (done) chk("ign_diff", 32'(diff), 32'd99);
      tick();
    end
    chk("ign_done_count", 32'(done_cnt), 32'd1);
    chk("ign_idle", 32'(busy), 32'd0);
    chk("ign_diff_hold", 32'(diff), 32'd99);

    // 5. Reset mid-RUN aborts without a done pulse
    a = 8'd50; b = 8'd20; b_in = 1'b0; start = 1'b1;
    tick();                      // edge N
    start = 1'b0;
    tick(); tick();              // N+1, N+2
    rst = 1'b1;
    tick();                      // N+3
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) done_cnt++;
      tick();
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    op(8'd9, 8'd4, 1'b0, 8'd5, 1'b0, "after_abort");

    // 6. Back-to-back with start held high; operands scrambled during RUN
    ea = 8'($urandom); eb = 8'($urandom); ebin = 1'($urandom);
    a = ea; b = eb; b_in = ebin; start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      model = {1'b0, ea} - {1'b0, eb} - 9'(ebin);
      tick();                    // accepting edge
      for (int k = 1; k < int'(W); k++) begin
        a = 8'($urandom); b = 8'($urandom); b_in = 1'($urandom);
        tick();
      end
      tick();                    // edge N+W
      chk("b2b_done", 32'(done), 32'd1);
      chk("b2b_diff", 32'(diff), 32'(model[W-1:0]));
      chk("b2b_borrow", 32'(borrow_out), 32'(model[W]));
      tick();                    // edge N+W+1
      chk("b2b_gap", 32'(done), 32'd0);
      ea = 8'($urandom); eb = 8'($urandom); ebin = 1'($urandom);
      a = ea; b = eb; b_in = ebin;
    end
    start = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
